// File: rtl/demux_1_to_4_buffered_pkg.sv
// Shared CORDIC fan-out definitions: channel select encodings, default word
// width and the per-channel holding-slot state type.
package demux_1_to_4_buffered_pkg;

  localparam int DEFAULT_WORD_WIDTH = 16;

  localparam logic [1:0] CH_X  = 2'd0;
  localparam logic [1:0] CH_Y  = 2'd1;
  localparam logic [1:0] CH_Z  = 2'd2;
  localparam logic [1:0] CH_ST = 2'd3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel. The EMPTY/FULL
// state bit is the channel's out_valid, so the FSM state is directly visible.
module demux_slot
  import demux_1_to_4_buffered_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_data
);

  slot_state_e           state_q, state_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  drain;

  assign drain = (state_q == SLOT_FULL) && out_ready;

  // A load wins over a drain, which gives bubble-free pass-through.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = in_data;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;

endmodule

// File: rtl/demux_1_to_4_buffered.sv
// Routes one input word stream to one of four independently back-pressured
// output channels, each buffered by a one-entry slot (1-cycle latency).
module demux_1_to_4_buffered
  import demux_1_to_4_buffered_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic [WORD_WIDTH-1:0] out1,
  output logic [WORD_WIDTH-1:0] out2,
  output logic [WORD_WIDTH-1:0] out3,
  output logic [WORD_WIDTH-1:0] out4,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic                  busy
);

  // Handshake: a word moves on any edge where valid && ready; ready never
  // depends on valid, and a held word stays stable until its ready is seen.
  logic                  accept;
  logic [3:0]            load_vec;
  logic [WORD_WIDTH-1:0] slot_data [4];

  assign in_ready = !out_valid[sel] || out_ready[sel];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load_vec = 4'b0000;
    if (accept) begin
      unique case (sel)
        CH_X:  load_vec[0] = 1'b1;
        CH_Y:  load_vec[1] = 1'b1;
        CH_Z:  load_vec[2] = 1'b1;
        CH_ST: load_vec[3] = 1'b1;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_slot
    demux_slot #(
      .WORD_WIDTH(WORD_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load_vec[k]),
      .in_data  (in_data),
      .out_ready(out_ready[k]),
      .out_valid(out_valid[k]),
      .out_data (slot_data[k])
    );
  end

  assign out1 = slot_data[0];
  assign out2 = slot_data[1];
  assign out3 = slot_data[2];
  assign out4 = slot_data[3];
  assign busy = |out_valid;

endmodule

// File: tb/tb_demux_1_to_4_buffered.sv
// Bench for demux_1_to_4_buffered: directed scenarios followed by a random
// phase checked against an array model of the four channel slots.
module tb_demux_1_to_4_buffered;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] out1, out2, out3, out4;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];

  demux_1_to_4_buffered #(.WORD_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Inputs are driven at the falling edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; sel = 2'd2; in_data = 16'hAAAA; out_ready = 4'b0000;
    tick();
    tick();
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready_during got %b want 1", in_ready);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, in_ready, out1, out2, out3, out4} !== {4'b0000, 1'b0, 1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL reset_state got v=%b busy=%b rdy=%b o=%h %h %h %h want v=0000 busy=0 rdy=1 o=0",
               out_valid, busy, in_ready, out1, out2, out3, out4);
    end
  endtask

  task automatic test_single_route();
    out_ready = 4'b0000; sel = 2'd2; in_data = 16'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (out3 !== 16'h1234 || out_valid !== 4'b0100 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_route_hold c=%0d got out3=%h v=%b busy=%b want 1234 0100 1", c, out3, out_valid, busy);
      end
      tick();
    end
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    n_cmp++;
    if (out_valid !== 4'b0000 || out3 !== 16'h1234) begin
      n_fail++; $display("FAIL single_route_drain got v=%b out3=%h want 0000 1234", out_valid, out3);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b0000; sel = 2'd0; in_data = 16'h0001; in_valid = 1'b1;
    tick();
    in_data = 16'h0002;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_in_ready got %b want 0", in_ready);
    end
    tick();
    n_cmp++;
    if (out1 !== 16'h0001 || out_valid !== 4'b0001) begin
      n_fail++; $display("FAIL backpressure_hold got out1=%h v=%b want 0001 0001", out1, out_valid);
    end
    sel = 2'd1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_switch_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out2 !== 16'h0002 || out1 !== 16'h0001 || out_valid !== 4'b0011) begin
      n_fail++; $display("FAIL backpressure_switch got out1=%h out2=%h v=%b want 0001 0002 0011", out1, out2, out_valid);
    end
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
  endtask

  task automatic test_throughput();
    logic [W-1:0] exp_w;
    out_ready = 4'b1111; sel = 2'd3; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = W'(i);
      exp_q.push_back(W'(i));
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL throughput_in_ready i=%0d got %b want 1", i, in_ready);
      end
      tick();
      exp_w = exp_q.pop_front();
      n_cmp++;
      if (out4 !== exp_w || out_valid[3] !== 1'b1) begin
        n_fail++; $display("FAIL throughput_word i=%0d got out4=%h v3=%b want %h 1", i, out4, out_valid[3], exp_w);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 4'b0000 || out4 !== 16'h0004) begin
      n_fail++; $display("FAIL throughput_drain got v=%b out4=%h want 0000 0004", out_valid, out4);
    end
    out_ready = 4'b0000;
  endtask

  task automatic test_concurrent();
    out_ready = 4'b0000; sel = 2'd1; in_data = 16'h0055; in_valid = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 4'b0010) begin
      n_fail++; $display("FAIL concurrent_pre got v=%b want 0010", out_valid);
    end
    out_ready = 4'b0010; sel = 2'd3; in_data = 16'h0077;
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    n_cmp++;
    if (out_valid !== 4'b1000 || out4 !== 16'h0077 || out2 !== 16'h0055) begin
      n_fail++; $display("FAIL concurrent_post got v=%b out2=%h out4=%h want 1000 0055 0077", out_valid, out2, out4);
    end
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
  endtask

  task automatic test_mid_reset();
    out_ready = 4'b0000; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k); in_data = 16'hC000 + W'(k);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 4'b1111 || busy !== 1'b1 || out1 !== 16'hC000 || out4 !== 16'hC003) begin
      n_fail++; $display("FAIL mid_reset_full got v=%b busy=%b out1=%h out4=%h want 1111 1 c000 c003", out_valid, busy, out1, out4);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, busy, out1, out2, out3, out4} !== {4'b0000, 1'b0, 64'h0}) begin
      n_fail++; $display("FAIL mid_reset_clear got v=%b busy=%b o=%h %h %h %h want all 0", out_valid, busy, out1, out2, out3, out4);
    end
  endtask

  // Model: per channel a "holds a word" flag and the last word loaded.
  task automatic test_random();
    logic [3:0]   m_valid;
    logic [W-1:0] m_data [4];
    logic         exp_ready;
    m_valid = 4'b0000;
    for (int k = 0; k < 4; k++) m_data[k] = '0;
    for (int c = 0; c < 500; c++) begin
      rst       = ($urandom_range(0, 40) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      in_data   = W'($urandom);
      out_ready = 4'($urandom);
      #1;
      exp_ready = !m_valid[sel] || out_ready[sel];
      n_cmp++;
      if (in_ready !== exp_ready) begin
        n_fail++; $display("FAIL random_in_ready c=%0d got %b want %b", c, in_ready, exp_ready);
      end
      for (int k = 0; k < 4; k++) begin
        if (rst) begin
          m_valid[k] = 1'b0; m_data[k] = '0;
        end else if (in_valid && exp_ready && int'(sel) == k) begin
          m_valid[k] = 1'b1; m_data[k] = in_data;
        end else if (m_valid[k] && out_ready[k]) begin
          m_valid[k] = 1'b0;
        end
      end
      tick();
      n_cmp++;
      if ({out_valid, busy, out1, out2, out3, out4} !==
          {m_valid, |m_valid, m_data[0], m_data[1], m_data[2], m_data[3]}) begin
        n_fail++;
        $display("FAIL random_outputs c=%0d got v=%b busy=%b o=%h %h %h %h want v=%b busy=%b o=%h %h %h %h",
                 c, out_valid, busy, out1, out2, out3, out4,
                 m_valid, |m_valid, m_data[0], m_data[1], m_data[2], m_data[3]);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 2'd0; in_data = '0; out_ready = 4'b0000;
    test_reset();
    test_single_route();
    test_backpressure();
    test_throughput();
    test_concurrent();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
